// File: rtl/sreg_bus_master_pkg.sv
// sreg_bus_master_pkg: shared op codes, FSM encoding and width defaults
package sreg_bus_master_pkg;
  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {OP_SET_ADDR, OP_INC, OP_WRITE, OP_READ} op_e;
  typedef enum logic [3:0] {
    IDLE, SHIFT_LO, SHIFT_HI, INC_LO, INC_HI, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, RD_DONE
  } state_e;
endpackage

// File: rtl/sreg_bus_master_if.sv
// sreg_bus_master_if: command/response handshake plus CPLD/SRAM bus pins
interface sreg_bus_master_if import sreg_bus_master_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic cmd_valid, cmd_ready, rsp_valid;
  op_e cmd_op;
  logic [ADDR_W-1:0] cmd_addr, cur_addr;
  logic [DATA_W-1:0] cmd_wdata, rsp_rdata, avr_data_out, avr_data_in;
  logic avr_sreg_clk, avr_si, avr_sreg_en, avr_counter, avr_we, avr_oe, avr_data_oe;
  modport master(
    input cmd_valid, cmd_op, cmd_addr, cmd_wdata, avr_data_in,
    output cmd_ready, rsp_valid, rsp_rdata, cur_addr, avr_sreg_clk, avr_si, avr_sreg_en,
           avr_counter, avr_we, avr_oe, avr_data_out, avr_data_oe
  );
  modport slave(
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, avr_data_in,
    input cmd_ready, rsp_valid, rsp_rdata, cur_addr, avr_sreg_clk, avr_si, avr_sreg_en,
          avr_counter, avr_we, avr_oe, avr_data_out, avr_data_oe
  );
endinterface

// File: rtl/sreg_tx_shifter.sv
// sreg_tx_shifter: MSB-first serializer, one low then one high sclk cycle per bit
module sreg_tx_shifter #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  output logic         sclk,
  output logic         si,
  output logic         active,
  output logic         done
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  assign si = active & sh[W-1];
  // done marks the high half of the final bit
  assign done = active & sclk & (cnt == '0);
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      sclk <= 1'b0;
      active <= 1'b0;
    end else if (start) begin
      sh <= data;
      cnt <= CW'(W - 1);
      sclk <= 1'b0;
      active <= 1'b1;
    end else if (active) begin
      sclk <= ~sclk;
      if (sclk) begin
        sh <= sh << 1;
        cnt <= cnt - 1'b1;
        active <= cnt != '0;
      end
    end
endmodule

// File: rtl/sreg_bus_master.sv
// sreg_bus_master: loads the CPLD address register serially and strobes SRAM reads/writes
module sreg_bus_master import sreg_bus_master_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STROBE_CYC = 4
) (
  input logic avr_clk,
  input logic avr_reset,
  sreg_bus_master_if.master bus
);
  state_e st;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q, dout_q;
  logic [3:0] cnt;
  logic inc_clk, sh_start, sh_clk, sh_si, sh_active, sh_done;
  assign sh_start = bus.cmd_valid && st == IDLE && bus.cmd_op == OP_SET_ADDR;
  sreg_tx_shifter #(.W(ADDR_W)) u_shift (
    .clk(avr_clk), .rst(avr_reset), .start(sh_start), .data(bus.cmd_addr),
    .sclk(sh_clk), .si(sh_si), .active(sh_active), .done(sh_done)
  );
  assign bus.cmd_ready = st == IDLE;
  assign bus.avr_sreg_clk = sh_clk | inc_clk;
  assign bus.avr_si = sh_si;
  assign bus.avr_sreg_en = ~sh_active;
  assign bus.rsp_rdata = rdata_q;
  assign bus.avr_data_out = dout_q;
  always_ff @(posedge avr_clk)
    if (avr_reset) begin
      st <= IDLE;
      addr_q <= '0;
      rdata_q <= '0;
      dout_q <= '0;
      cnt <= '0;
      inc_clk <= 1'b0;
      bus.cur_addr <= '0;
      bus.rsp_valid <= 1'b0;
      bus.avr_counter <= 1'b1;
      bus.avr_we <= 1'b1;
      bus.avr_oe <= 1'b1;
      bus.avr_data_oe <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (st)
        IDLE: if (bus.cmd_valid)
          case (bus.cmd_op)
            OP_SET_ADDR: begin st <= SHIFT_LO; addr_q <= bus.cmd_addr; end
            OP_INC: begin st <= INC_LO; bus.avr_counter <= 1'b0; end
            OP_WRITE: begin st <= WR_SETUP; bus.avr_data_oe <= 1'b1; dout_q <= bus.cmd_wdata; end
            default: begin st <= RD_STROBE; bus.avr_oe <= 1'b0; cnt <= 4'(STROBE_CYC - 1); end
          endcase
        SHIFT_LO: st <= SHIFT_HI;
        // cur_addr only moves once every bit has been clocked in
        SHIFT_HI: if (sh_done) begin st <= IDLE; bus.cur_addr <= addr_q; end else st <= SHIFT_LO;
        INC_LO: begin st <= INC_HI; inc_clk <= 1'b1; end
        INC_HI: begin
          st <= IDLE;
          inc_clk <= 1'b0;
          bus.avr_counter <= 1'b1;
          bus.cur_addr <= bus.cur_addr + 1'b1;
        end
        WR_SETUP: begin st <= WR_STROBE; bus.avr_we <= 1'b0; cnt <= 4'(STROBE_CYC - 1); end
        WR_STROBE: if (cnt == '0) begin st <= WR_HOLD; bus.avr_we <= 1'b1; end else cnt <= cnt - 1'b1;
        WR_HOLD: begin st <= IDLE; bus.avr_data_oe <= 1'b0; end
        RD_STROBE: if (cnt == '0) begin
          st <= RD_DONE;
          bus.avr_oe <= 1'b1;
          bus.rsp_valid <= 1'b1;
          rdata_q <= bus.avr_data_in;
        end else cnt <= cnt - 1'b1;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sreg_bus_master.sv
// tb_sreg_bus_master: randomized commands checked cycle by cycle against a timeline model
module tb_sreg_bus_master;
  import sreg_bus_master_pkg::*;
  localparam int AW = 21, DW = 8, S = 4;
  typedef struct packed {
    logic sclk, si, en, ctr, we, oe, doe, rv, ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata, dout;
  } exp_t;
  logic avr_clk = 1'b0, avr_reset = 1'b1;
  always #5 avr_clk = ~avr_clk;
  sreg_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  sreg_bus_master #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S)) dut (
    .avr_clk(avr_clk), .avr_reset(avr_reset), .bus(bus)
  );
  exp_t q[$];
  exp_t exp_cur;
  logic [DW-1:0] din_q[$];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rdata = '0, din_val = '0;
  logic [31:0] si_log = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 0;
  int edges = 0, ctr_low = 0, we_low = 0, oe_low = 0, doe_hi = 0, rv_n = 0;
  int e0, c0, w0, d0, o0, r0;
  bit prev_sclk = 1'b0, chk_en = 1'b0, din_force = 1'b0;
  op_e rop;

  function automatic exp_t base(bit ready);
    exp_t e;
    e = '0;
    e.en = 1'b1;
    e.ctr = 1'b1;
    e.we = 1'b1;
    e.oe = 1'b1;
    e.ready = ready;
    e.addr = m_addr;
    e.rdata = m_rdata;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // expected outputs for cycles 1..N after acceptance, built from the per-op timing rules
  task automatic push_cmd(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_t e;
    logic [DW-1:0] v;
    e = base(1'b0);
    v = '0;
    case (op)
      OP_SET_ADDR: begin
        e.en = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
          e.si = a[i];
          e.sclk = 1'b0;
          q.push_back(e);
          e.sclk = 1'b1;
          q.push_back(e);
        end
        m_addr = a;
      end
      OP_INC: begin
        e.ctr = 1'b0;
        q.push_back(e);
        e.sclk = 1'b1;
        q.push_back(e);
        m_addr = m_addr + 1'b1;
      end
      OP_WRITE: begin
        e.doe = 1'b1;
        e.dout = w;
        q.push_back(e);
        e.we = 1'b0;
        repeat (S) q.push_back(e);
        e.we = 1'b1;
        q.push_back(e);
      end
      default: begin
        e.oe = 1'b0;
        repeat (S) begin
          v = din_force ? din_val : DW'($urandom);
          din_q.push_back(v);
          q.push_back(e);
        end
        m_rdata = v;
        e.oe = 1'b1;
        e.rv = 1'b1;
        e.rdata = v;
        q.push_back(e);
      end
    endcase
  endtask

  task automatic drive(input bit v, input bit r, input op_e op, input logic [AW-1:0] a,
                       input logic [DW-1:0] w);
    bus.cmd_valid = v;
    bus.cmd_op = op;
    bus.cmd_addr = a;
    bus.cmd_wdata = w;
    avr_reset = r;
    bus.avr_data_in = din_q.size() != 0 ? din_q.pop_front() : DW'($urandom);
    if (r) begin
      q.delete();
      din_q.delete();
      m_addr = '0;
      m_rdata = '0;
    end else if (v && exp_cur.ready) push_cmd(op, a, w);
  endtask

  task automatic compare();
    exp_t g;
    g = {bus.avr_sreg_clk, bus.avr_si, bus.avr_sreg_en, bus.avr_counter, bus.avr_we, bus.avr_oe,
         bus.avr_data_oe, bus.rsp_valid, bus.cmd_ready, bus.cur_addr, bus.rsp_rdata,
         bus.avr_data_oe ? bus.avr_data_out : DW'(0)};
    check($sformatf("cycle%0d_outputs", cyc), 64'(g), 64'(exp_cur));
    if (bus.avr_sreg_clk && !prev_sclk) begin
      edges++;
      si_log = {si_log[30:0], bus.avr_si};
    end
    prev_sclk = bus.avr_sreg_clk;
    if (!bus.avr_counter) ctr_low++;
    if (!bus.avr_we) we_low++;
    if (!bus.avr_oe) oe_low++;
    if (bus.avr_data_oe) doe_hi++;
    if (bus.rsp_valid) rv_n++;
  endtask

  task automatic step();
    @(negedge avr_clk);
    if (chk_en) compare();
    @(posedge avr_clk);
    #1;
    cyc++;
    exp_cur = q.size() != 0 ? q.pop_front() : base(1'b1);
  endtask

  task automatic run_cmd(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input bit noise, input int rst_at);
    step();
    drive(1'b1, 1'b0, op, a, w);
    lat = 0;
    for (int i = 1; i < 100; i++) begin
      step();
      if (lat == 0 && bus.cmd_ready) lat = i;
      if (exp_cur.ready) begin
        drive(1'b0, 1'b0, op, a, w);
        return;
      end
      if (i == rst_at) begin
        drive(1'b0, 1'b1, op, a, w);
        step();
        drive(1'b0, 1'b0, op, a, w);
        return;
      end
      drive(noise ? 1'($urandom) : 1'b0, 1'b0, op_e'($urandom_range(0, 3)), AW'($urandom),
            DW'($urandom));
    end
    n_chk++;
    n_fail++;
    $display("FAIL run_cmd_timeout: got no idle cycle expected idle within 100 cycles");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_SET_ADDR;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.avr_data_in = '0;
    exp_cur = base(1'b1);
    drive(1'b0, 1'b1, OP_SET_ADDR, '0, '0);
    step();
    drive(1'b0, 1'b1, OP_SET_ADDR, '0, '0);
    step();
    chk_en = 1'b1;
    drive(1'b0, 1'b0, OP_SET_ADDR, '0, '0);
    check("reset_ready", 64'(bus.cmd_ready), 64'(1));
    check("reset_cur_addr", 64'(bus.cur_addr), 64'(0));
    check("reset_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("reset_sreg_en", 64'(bus.avr_sreg_en), 64'(1));

    e0 = edges;
    run_cmd(OP_SET_ADDR, 21'h15A5A5, 8'h00, 1'b1, 0);
    check("set_edges", 64'(edges - e0), 64'(21));
    check("set_si_bits", 64'(si_log[20:0]), 64'(21'h15A5A5));
    check("set_cur_addr", 64'(bus.cur_addr), 64'(21'h15A5A5));
    check("set_ready_cycle", 64'(lat), 64'(43));

    run_cmd(OP_SET_ADDR, 21'h1FFFFF, 8'h00, 1'b0, 0);
    c0 = ctr_low;
    run_cmd(OP_INC, '0, 8'h00, 1'b1, 0);
    check("inc_counter_low", 64'(ctr_low - c0), 64'(2));
    check("inc_wrap_addr", 64'(bus.cur_addr), 64'(0));
    check("inc_ready_cycle", 64'(lat), 64'(3));

    w0 = we_low;
    d0 = doe_hi;
    run_cmd(OP_WRITE, '0, 8'h3C, 1'b1, 0);
    check("wr_we_low", 64'(we_low - w0), 64'(4));
    check("wr_data_oe", 64'(doe_hi - d0), 64'(6));
    check("wr_ready_cycle", 64'(lat), 64'(7));

    din_force = 1'b1;
    din_val = 8'hA7;
    o0 = oe_low;
    r0 = rv_n;
    run_cmd(OP_READ, '0, 8'h00, 1'b1, 0);
    din_force = 1'b0;
    check("rd_oe_low", 64'(oe_low - o0), 64'(4));
    check("rd_rsp_valid", 64'(rv_n - r0), 64'(1));
    check("rd_rdata", 64'(bus.rsp_rdata), 64'(8'hA7));

    run_cmd(OP_SET_ADDR, 21'h012345, 8'h00, 1'b0, 0);
    run_cmd(OP_SET_ADDR, 21'h0ABCDE, 8'h00, 1'b1, 10);
    check("rst_sreg_en", 64'(bus.avr_sreg_en), 64'(1));
    check("rst_cur_addr", 64'(bus.cur_addr), 64'(0));
    check("rst_ready", 64'(bus.cmd_ready), 64'(1));

    for (int k = 0; k < 250; k++) begin
      rop = op_e'($urandom_range(0, 3));
      run_cmd(rop, ($urandom % 4 == 0) ? {AW{1'b1}} : AW'($urandom), DW'($urandom), 1'($urandom),
              ($urandom % 8 == 0) ? int'($urandom_range(1, 40)) : 0);
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
